i2c_cfg_sequencer: RTL and testbench

- Generalised register-configuration sequencer for the CMOS sensor I2C path.
- Walks an external combinational config LUT of {register address, data} entries and issues one write per entry to the I2C master through a req/done/err handshake.
- Adds behaviour a plain LUT does not have: parametrised address/data/index widths, in-table delay entries, bounded retry on NACK, response timeout, error reporting and restart.
- Sits between the sensor config LUT and the I2C master, and gates the sensor-ready flag for the capture pipeline.

---
 rtl/i2c_cfg_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_i2c_cfg_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cfg_sequencer.sv
// Sensor register-configuration sequencer: walks an {addr,data} LUT and issues one
// I2C write per entry, with in-table delays, bounded retry, response timeout and abort.
module i2c_cfg_sequencer #(
    parameter int unsigned       ADDR_W       = 16,
    parameter int unsigned       DATA_W       = 8,
    parameter int unsigned       INDEX_W      = 9,
    parameter logic [ADDR_W-1:0] DELAY_ADDR   = {ADDR_W{1'b1}},
    parameter int unsigned       DELAY_UNIT   = 50000,
    parameter int unsigned       MAX_RETRY    = 3,
    parameter int unsigned       RESP_TIMEOUT = 100000,
    parameter bit                AUTO_START   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [INDEX_W:0]         lut_size,
    output logic [INDEX_W-1:0]       lut_index,
    input  logic [ADDR_W+DATA_W-1:0] lut_data,
    output logic                     i2c_req,
    output logic [ADDR_W-1:0]        i2c_addr,
    output logic [DATA_W-1:0]        i2c_wdata,
    input  logic                     i2c_done,
    input  logic                     i2c_err,
    output logic                     busy,
    output logic                     cfg_done,
    output logic                     cfg_error,
    output logic [INDEX_W-1:0]       err_index
);

    localparam int unsigned UNIT_W = $clog2(DELAY_UNIT + 1);
    localparam int unsigned DLY_W  = DATA_W + UNIT_W;
    localparam int unsigned TMR_W  = $clog2(RESP_TIMEOUT + 1);
    localparam int unsigned RTY_W  = $clog2(MAX_RETRY + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_CHECK, S_REQ, S_WAIT, S_DELAY, S_NEXT, S_DONE, S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [INDEX_W-1:0]  idx_d, eidx_d;
    logic [ADDR_W-1:0]   entry_addr_q, entry_addr_d, addr_d;
    logic [DATA_W-1:0]   entry_data_q, entry_data_d, wdata_d;
    logic [RTY_W-1:0]    retry_q, retry_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [DLY_W-1:0]    dly_q, dly_d;
    logic                req_d, busy_d, done_d, error_d;
    logic                auto_q;
    logic [INDEX_W:0]    idx_plus1_c;
    logic                last_entry_c;
    logic                attempt_fail_c;

    // State and all outputs are registered from next-state values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            lut_index    <= '0;
            entry_addr_q <= '0;
            entry_data_q <= '0;
            retry_q      <= '0;
            tmr_q        <= '0;
            dly_q        <= '0;
            i2c_req      <= 1'b0;
            i2c_addr     <= '0;
            i2c_wdata    <= '0;
            busy         <= 1'b0;
            cfg_done     <= 1'b0;
            cfg_error    <= 1'b0;
            err_index    <= '0;
            auto_q       <= AUTO_START;
        end else begin
            state_q      <= state_d;
            lut_index    <= idx_d;
            entry_addr_q <= entry_addr_d;
            entry_data_q <= entry_data_d;
            retry_q      <= retry_d;
            tmr_q        <= tmr_d;
            dly_q        <= dly_d;
            i2c_req      <= req_d;
            i2c_addr     <= addr_d;
            i2c_wdata    <= wdata_d;
            busy         <= busy_d;
            cfg_done     <= done_d;
            cfg_error    <= error_d;
            err_index    <= eidx_d;
            auto_q       <= 1'b0;
        end
    end

    assign idx_plus1_c    = (INDEX_W+1)'({1'b0, lut_index}) + (INDEX_W+1)'(1);
    assign last_entry_c   = (idx_plus1_c == lut_size);
    // err has priority over a coincident done; timeout counts as a failed attempt
    assign attempt_fail_c = i2c_err || (tmr_q == TMR_W'(RESP_TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        idx_d        = lut_index;
        entry_addr_d = entry_addr_q;
        entry_data_d = entry_data_q;
        retry_d      = retry_q;
        tmr_d        = tmr_q;
        dly_d        = dly_q;
        req_d        = i2c_req;
        addr_d       = i2c_addr;
        wdata_d      = i2c_wdata;
        busy_d       = busy;
        done_d       = cfg_done;
        error_d      = cfg_error;
        eidx_d       = err_index;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start || auto_q) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                    retry_d = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (lut_size == '0) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    entry_addr_d = lut_data[DATA_W +: ADDR_W];
                    entry_data_d = lut_data[DATA_W-1:0];
                    state_d      = S_CHECK;
                end
            end
            S_CHECK: begin
                if (entry_addr_q == DELAY_ADDR) begin
                    if (entry_data_q == '0) begin
                        state_d = S_NEXT;
                    end else begin
                        state_d = S_DELAY;
                        dly_d   = DLY_W'(entry_data_q) * DLY_W'(DELAY_UNIT);
                    end
                end else begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
                req_d   = 1'b1;
                addr_d  = entry_addr_q;
                wdata_d = entry_data_q;
                tmr_d   = '0;
            end
            S_WAIT: begin
                if (attempt_fail_c) begin
                    req_d   = 1'b0;
                    retry_d = retry_q + RTY_W'(1);
                    if (retry_q < RTY_W'(MAX_RETRY - 1)) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_ERROR;
                        busy_d  = 1'b0;
                        error_d = 1'b1;
                        eidx_d  = lut_index;
                    end
                end else if (i2c_done) begin
                    req_d   = 1'b0;
                    state_d = S_NEXT;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_DELAY: begin
                if (dly_q <= DLY_W'(1)) begin
                    dly_d   = '0;
                    state_d = S_NEXT;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            S_NEXT: begin
                retry_d = '0;
                if (last_entry_c) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = lut_index + INDEX_W'(1);
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Scoreboard bench for i2c_cfg_sequencer: a reference model derives the expected write
// attempts and final outcome from the LUT and a scripted I2C master response plan.
module tb_i2c_cfg_sequencer;

    localparam int ADDR_W       = 16;
    localparam int DATA_W       = 8;
    localparam int INDEX_W      = 9;
    localparam int DELAY_UNIT   = 10;
    localparam int MAX_RETRY    = 3;
    localparam int RESP_TIMEOUT = 20;
    localparam int BUDGET       = 20000;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     start = 1'b0;
    logic [INDEX_W:0]         lut_size = '0;
    logic [INDEX_W-1:0]       lut_index, err_index;
    logic [ADDR_W+DATA_W-1:0] lut_data;
    logic                     i2c_req, i2c_done = 1'b0, i2c_err = 1'b0;
    logic [ADDR_W-1:0]        i2c_addr;
    logic [DATA_W-1:0]        i2c_wdata;
    logic                     busy, cfg_done, cfg_error;

    logic [ADDR_W+DATA_W-1:0] lut [0:(1<<INDEX_W)-1];
    assign lut_data = lut[lut_index];

    i2c_cfg_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INDEX_W(INDEX_W),
        .DELAY_ADDR(16'hFFFF), .DELAY_UNIT(DELAY_UNIT), .MAX_RETRY(MAX_RETRY),
        .RESP_TIMEOUT(RESP_TIMEOUT), .AUTO_START(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .lut_size(lut_size),
        .lut_index(lut_index), .lut_data(lut_data), .i2c_req(i2c_req),
        .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata), .i2c_done(i2c_done),
        .i2c_err(i2c_err), .busy(busy), .cfg_done(cfg_done),
        .cfg_error(cfg_error), .err_index(err_index)
    );

    always #5 clk = ~clk;

    // code: 0 ack, 1 nack, 2 silent, 3 done+err together
    typedef struct { int code; int lat; } resp_t;
    typedef struct { logic [15:0] addr; logic [7:0] data; int len; int min_gap; } exp_t;

    resp_t resp_q[$];
    exp_t  exp_q[$];
    int    tests = 0;
    int    fails = 0;
    bit    stray_en = 1'b0;
    int    plan [0:15];
    bit    exp_done;
    int    exp_idx, exp_eidx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Expected attempts and outcome from the table, the failure plan and the timing rules
    task automatic model(input int size, input int kind, input int lat);
        int gap;
        gap      = 0;
        exp_done = 1'b1;
        exp_idx  = (size == 0) ? 0 : size - 1;
        exp_eidx = 0;
        for (int i = 0; i < size; i++) begin
            logic [15:0] a;
            logic [7:0]  d;
            {a, d} = lut[i];
            if (a == 16'hFFFF) begin
                gap += int'(d) * DELAY_UNIT;
                continue;
            end
            for (int k = 0; k <= plan[i] && k < MAX_RETRY; k++) begin
                resp_t r;
                exp_t  e;
                r.lat  = (lat != 0) ? lat : int'($urandom_range(1, 6));
                r.code = (k < plan[i]) ? ((kind != 0) ? kind : int'($urandom_range(1, 3))) : 0;
                e.addr = a;
                e.data = d;
                e.len  = (r.code == 2) ? RESP_TIMEOUT : r.lat + 1;
                e.min_gap = (k == 0) ? gap : 1;
                gap = 0;
                resp_q.push_back(r);
                exp_q.push_back(e);
            end
            if (plan[i] >= MAX_RETRY) begin
                exp_done = 1'b0;
                exp_idx  = i;
                exp_eidx = i;
                return;
            end
        end
    endtask

    // I2C master: answers each new request according to the scripted response queue
    initial begin : master
        bit m_prev;
        m_prev = 1'b0;
        forever begin
            @(posedge clk); #1;
            i2c_done = 1'b0;
            i2c_err  = 1'b0;
            if (i2c_req && !m_prev) begin
                resp_t r;
                r.code = 2;
                r.lat  = 1;
                if (resp_q.size() != 0) r = resp_q.pop_front();
                if (r.code == 2) begin
                    for (int n = 0; i2c_req && n < 4 * RESP_TIMEOUT; n++) begin
                        @(posedge clk); #1;
                    end
                end else begin
                    repeat (r.lat) @(posedge clk);
                    #1;
                    i2c_done = (r.code == 0 || r.code == 3);
                    i2c_err  = (r.code == 1 || r.code == 3);
                end
            end else if (!i2c_req && stray_en && $urandom_range(0, 7) == 0) begin
                i2c_done = 1'($urandom_range(0, 1));
                i2c_err  = !i2c_done;
            end
            m_prev = i2c_req;
        end
    end

    // Monitor: pops one expected attempt per rising i2c_req and checks payload, gap, length
    initial begin : monitor
        bit   prev, have;
        int   len, low;
        exp_t cur;
        prev = 1'b0; have = 1'b0; len = 0; low = 0;
        forever begin
            @(posedge clk); #1;
            if (i2c_req && !prev) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_req: addr 0x%0h data 0x%0h, expected no request at %0t",
                             i2c_addr, i2c_wdata, $time);
                    have = 1'b0;
                end else begin
                    cur  = exp_q.pop_front();
                    have = 1'b1;
                    chk("req_addr", 32'(i2c_addr), 32'(cur.addr));
                    chk("req_data", 32'(i2c_wdata), 32'(cur.data));
                    chk("req_gap_ok", 32'(low >= cur.min_gap), 32'd1);
                end
                len = 1;
            end else if (i2c_req) begin
                len++;
                if (have) chk("req_stable", 32'({i2c_addr, i2c_wdata}), 32'({cur.addr, cur.data}));
            end else if (prev) begin
                if (have && cur.len != 0) chk("req_len", 32'(len), 32'(cur.len));
                have = 1'b0;
                low  = 1;
            end else begin
                low++;
            end
            prev = i2c_req;
        end
    end

    task automatic reset_checks(input string tag);
        chk({tag, "_req"}, 32'(i2c_req), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(cfg_done), 32'd0);
        chk({tag, "_error"}, 32'(cfg_error), 32'd0);
        chk({tag, "_index"}, 32'(lut_index), 32'd0);
        chk({tag, "_err_index"}, 32'(err_index), 32'd0);
        chk({tag, "_addr_data"}, 32'({i2c_addr, i2c_wdata}), 32'd0);
    endtask

    task automatic wait_end(output int n, output int first_req);
        n = 0;
        first_req = 0;
        while (!(cfg_done || cfg_error) && n < BUDGET) begin
            @(posedge clk); #1;
            n++;
            if (i2c_req && first_req == 0) first_req = n;
        end
    endtask

    task automatic end_checks(input int n);
        if (n >= BUDGET) begin
            chk("sequence_timeout", 32'd1, 32'd0);
        end else begin
            chk("cfg_done", 32'(cfg_done), 32'(exp_done));
            chk("cfg_error", 32'(cfg_error), 32'(!exp_done));
            chk("busy_end", 32'(busy), 32'd0);
            chk("lut_index_end", 32'(lut_index), 32'(exp_idx));
            if (!exp_done) chk("err_index", 32'(err_index), 32'(exp_eidx));
        end
        repeat (4) @(posedge clk);
        #1;
        chk("exp_drained", 32'(exp_q.size()), 32'd0);
        chk("resp_drained", 32'(resp_q.size()), 32'd0);
        exp_q.delete();
        resp_q.delete();
    endtask

    task automatic run(input int size, input int kind, input int lat);
        int  n, first_req;
        bit  lat_chk;
        lat_chk  = (size > 0) && (lut[0][23:8] != 16'hFFFF);
        lut_size = (INDEX_W+1)'(size);
        model(size, kind, lat);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_clears_done_err", 32'({cfg_done, cfg_error}), 32'd0);
        wait_end(n, first_req);
        n++;
        if (lat_chk && n < BUDGET) chk("first_req_latency", 32'(first_req + 1), 32'd4);
        if (size == 0 && n < BUDGET) chk("empty_done_latency", 32'(n), 32'd2);
        end_checks(n);
    endtask

    task automatic clear_plan();
        foreach (plan[i]) plan[i] = 0;
    endtask

    task automatic fill_writes(input int size);
        for (int i = 0; i < size; i++) lut[i] = {16'h3000 + 16'(i), 8'(8'h10 + i)};
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n, fr;
        foreach (lut[i]) lut[i] = '0;
        clear_plan();

        // Auto-start after reset with a three-write table, master acks after 5 cycles
        lut[0] = {16'h0103, 8'h01};
        lut[1] = {16'h0100, 8'h00};
        lut[2] = {16'h0100, 8'h01};
        lut_size = 10'd3;
        model(3, 0, 5);
        repeat (3) @(posedge clk);
        #1;
        reset_checks("rst");
        @(negedge clk);
        rst_n = 1'b1;
        wait_end(n, fr);
        end_checks(n);

        // Delay entries, including a zero-length one
        lut[0] = {16'h0103, 8'h01};
        lut[1] = {16'hFFFF, 8'h03};
        lut[2] = {16'h0100, 8'h01};
        lut[3] = {16'hFFFF, 8'h00};
        lut[4] = {16'h0100, 8'h00};
        run(5, 0, 0);

        // Entry 1 NACKed twice then acked
        fill_writes(3);
        plan[1] = 2;
        run(3, 1, 0);

        // Entry 2 NACKed on every attempt -> abort, then full restart
        clear_plan();
        fill_writes(5);
        plan[2] = MAX_RETRY;
        run(5, 1, 0);
        clear_plan();
        run(5, 0, 0);

        // Silent master -> timeouts exhaust retries
        plan[0] = MAX_RETRY;
        run(1, 2, 0);
        // Coincident done+err counts as a failure
        clear_plan();
        plan[0] = 2;
        run(2, 3, 0);

        // Randomized tables and response plans
        stray_en = 1'b1;
        for (int t = 0; t < 15; t++) begin
            int size;
            size = int'($urandom_range(1, 8));
            clear_plan();
            for (int i = 0; i < size; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    lut[i] = {16'hFFFF, 8'($urandom_range(0, 3))};
                end else begin
                    lut[i] = {16'($urandom_range(0, 16'hFFFE)), 8'($urandom)};
                    if ($urandom_range(0, 9) >= 7) plan[i] = int'($urandom_range(1, MAX_RETRY));
                end
            end
            run(size, 0, 0);
        end
        stray_en = 1'b0;

        // Asynchronous reset in the middle of a WAIT
        clear_plan();
        lut[0] = {16'h1234, 8'h56};
        lut_size = 10'd1;
        resp_q.push_back('{code: 2, lat: 1});
        exp_q.push_back('{addr: 16'h1234, data: 8'h56, len: 0, min_gap: 0});
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; !i2c_req && k < 50; k++) begin
            @(posedge clk); #1;
        end
        chk("mid_wait_req_seen", 32'(i2c_req), 32'd1);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        reset_checks("rst_mid");
        lut_size = '0;
        model(0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_end(n, fr);
        end_checks(n);

        // Empty table started explicitly
        run(0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
